// File: rtl/cam_stream_tx.sv
// Emulated 8-bit parallel camera port: frame/line sync generation with RGB565 pixels
// sent high byte first, sourced from an external line buffer or a built-in pattern.
//
// state  | meaning
// IDLE   | waiting for EN, all outputs quiet
// VSYNC  | CamVsync high
// VBACK  | vertical back porch, first line prefetch
// HACT   | active bytes, CamHsync high
// HBLANK | horizontal blank, next line prefetch
// VFRONT | vertical front porch, FRAME_DONE on last cycle
module cam_stream_tx #(
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int H_BLANK      = 144,
  parameter int V_SYNC_CLKS  = 2352,
  parameter int V_BACK_CLKS  = 13328,
  parameter int V_FRONT_CLKS = 7840
) (
  input  logic        PCLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic [1:0]  PATTERN_SEL,
  input  logic [15:0] SOLID_COLOR,
  output logic [9:0]  LB_RD_ADDR,
  output logic        LB_RD_N,
  input  logic [15:0] LB_RD_DATA,
  output logic        LINE_START,
  output logic [8:0]  CUR_LINE,
  output logic        CamVsync,
  output logic        CamHsync,
  output logic [7:0]  CamData,
  output logic        FRAME_DONE
);

  localparam int LINE_BYTES = 2 * H_ACTIVE;
  localparam int MAX_A      = (LINE_BYTES > H_BLANK) ? LINE_BYTES : H_BLANK;
  localparam int MAX_B      = (V_SYNC_CLKS > V_BACK_CLKS) ? V_SYNC_CLKS : V_BACK_CLKS;
  localparam int MAX_C      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_LEN    = (MAX_C > V_FRONT_CLKS) ? MAX_C : V_FRONT_CLKS;
  localparam int CNT_W      = $clog2(MAX_LEN + 1);
  localparam int BAR_PIX    = H_ACTIVE / 8;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, HACT, HBLANK, VFRONT} state_t;

  state_t             state, nextState;
  logic [CNT_W-1:0]   cnt, nextCnt;
  logic [9:0]         lineCnt, nextLine;
  logic [1:0]         patSel;
  logic [15:0]        solidColor;
  logic [9:0]         fetchPix, fetchPixNext;
  logic [2:0]         barIdx;
  logic [6:0]         barCnt;
  logic [7:0]         lowByte;
  logic [15:0]        pixWord;
  logic               nextRead, firstPix, nextHigh, nextLow, enterFrame;

  function automatic logic [15:0] barColor(input logic [2:0] idx);
    case (idx)
      3'd0:    barColor = 16'hFFFF;
      3'd1:    barColor = 16'hFFE0;
      3'd2:    barColor = 16'h07FF;
      3'd3:    barColor = 16'h07E0;
      3'd4:    barColor = 16'hF81F;
      3'd5:    barColor = 16'hF800;
      3'd6:    barColor = 16'h001F;
      default: barColor = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      lineCnt <= '0;
    end else begin
      state   <= nextState;
      cnt     <= nextCnt;
      lineCnt <= nextLine;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt - 1'b1;
    nextLine  = lineCnt;
    case (state)
      IDLE: begin
        nextCnt = '0;
        if (EN) begin
          nextState = VSYNC;
          nextCnt   = CNT_W'(V_SYNC_CLKS - 1);
          nextLine  = '0;
        end
      end
      VSYNC: if (cnt == '0) begin
        nextState = VBACK;
        nextCnt   = CNT_W'(V_BACK_CLKS - 1);
      end
      VBACK: if (cnt == '0) begin
        nextState = HACT;
        nextCnt   = CNT_W'(LINE_BYTES - 1);
      end
      HACT: if (cnt == '0) begin
        nextState = HBLANK;
        nextCnt   = CNT_W'(H_BLANK - 1);
        nextLine  = lineCnt + 1'b1;
      end
      HBLANK: if (cnt == '0) begin
        if (lineCnt < 10'(V_ACTIVE)) begin
          nextState = HACT;
          nextCnt   = CNT_W'(LINE_BYTES - 1);
        end else begin
          nextState = VFRONT;
          nextCnt   = CNT_W'(V_FRONT_CLKS - 1);
        end
      end
      VFRONT: if (cnt == '0) begin
        if (EN) begin
          nextState = VSYNC;
          nextCnt   = CNT_W'(V_SYNC_CLKS - 1);
          nextLine  = '0;
        end else begin
          nextState = IDLE;
          nextCnt   = '0;
        end
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase
  end

  // Fetch for pixel p lands two cycles before byte 2p; in HACT the down-counter is odd on even bytes.
  always_comb begin
    enterFrame   = (nextState == VSYNC) && (state != VSYNC);
    nextRead     = ((nextState == VBACK) && (nextCnt == CNT_W'(1)))
                || ((nextState == HBLANK) && (nextCnt == CNT_W'(1)) && (nextLine < 10'(V_ACTIVE)))
                || ((nextState == HACT) && nextCnt[0] && (nextCnt > CNT_W'(1)));
    firstPix     = (nextState != HACT);
    fetchPixNext = firstPix ? 10'd0 : fetchPix + 10'd1;
    nextHigh     = (nextState == HACT) && nextCnt[0];
    nextLow      = (nextState == HACT) && !nextCnt[0];
    case (patSel)
      2'd0:    pixWord = LB_RD_DATA;
      2'd1:    pixWord = barColor(barIdx);
      2'd2:    pixWord = {6'd0, fetchPix} + {6'd0, lineCnt};
      default: pixWord = solidColor;
    endcase
  end

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      patSel     <= '0;
      solidColor <= '0;
      fetchPix   <= '0;
      barIdx     <= '0;
      barCnt     <= '0;
      lowByte    <= '0;
      LB_RD_ADDR <= '0;
      LB_RD_N    <= 1'b1;
      LINE_START <= 1'b0;
      CamVsync   <= 1'b0;
      CamHsync   <= 1'b0;
      CamData    <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      if (enterFrame) begin
        patSel     <= PATTERN_SEL;
        solidColor <= SOLID_COLOR;
      end
      if (nextRead) begin
        fetchPix <= fetchPixNext;
        if (firstPix || barCnt == '0) begin
          barIdx <= firstPix ? 3'd0 : barIdx + 3'd1;
          barCnt <= 7'(BAR_PIX - 1);
        end else begin
          barCnt <= barCnt - 7'd1;
        end
        if (patSel == 2'd0) LB_RD_ADDR <= fetchPixNext;
      end
      LB_RD_N    <= !(nextRead && patSel == 2'd0);
      LINE_START <= ((nextState == VBACK) && (state == VSYNC))
                 || ((nextState == HBLANK) && (state == HACT) && (nextLine < 10'(V_ACTIVE)));
      CamVsync   <= (nextState == VSYNC);
      CamHsync   <= (nextState == HACT);
      FRAME_DONE <= (nextState == VFRONT) && (nextCnt == '0);
      if (nextHigh) begin
        CamData <= pixWord[15:8];
        lowByte <= pixWord[7:0];
      end else if (nextLow) begin
        CamData <= lowByte;
      end else begin
        CamData <= '0;
      end
    end
  end

  assign CUR_LINE = lineCnt[8:0];

endmodule

// File: doc/cam_stream_tx.md
Name: cam_stream_tx

Overview:
- Camera-side transmitter that emulates an 8-bit parallel sensor port in the PCLK domain.
- Drives CamVsync, CamHsync and CamData. Each 16-bit RGB565 pixel is sent as two bytes, high byte first.
- Pixels come from an external line-buffer RAM or from a built-in test pattern.
- Used to drive the camera capture path in loopback and bench testing without a real sensor.

Parameters:
- H_ACTIVE, 320, pixels per line (2*H_ACTIVE byte cycles); must be a multiple of 8 and at most 1024.
- V_ACTIVE, 240, lines per frame; at most 512.
- H_BLANK, 144, PCLK cycles with CamHsync low after each line; at least 2.
- V_SYNC_CLKS, 2352, PCLK cycles with CamVsync high; at least 1.
- V_BACK_CLKS, 13328, PCLK cycles from CamVsync fall to the first line; at least 2.
- V_FRONT_CLKS, 7840, PCLK cycles after the last line's blank; at least 1.

Ports:
- PCLK  in  1  pixel/byte clock.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  frame enable; sampled only in IDLE and on the last VFRONT cycle.
- PATTERN_SEL  in  2  0 = line buffer, 1 = colour bars, 2 = ramp, 3 = solid.
- SOLID_COLOR  in  16  RGB565 word for pattern 3.
- LB_RD_ADDR  out  10  line-buffer pixel address.
- LB_RD_N  out  1  active-low read strobe; RAM data is valid the cycle after the strobe.
- LB_RD_DATA  in  16  line-buffer read data.
- LINE_START  out  1  one-cycle pulse: the line buffer may now be refilled with line CUR_LINE.
- CUR_LINE  out  9  index of the next line to be transmitted.
- CamVsync  out  1  frame sync, active high.
- CamHsync  out  1  high during active bytes only.
- CamData  out  8  byte data; 0 whenever CamHsync is low.
- FRAME_DONE  out  1  one-cycle pulse on the last VFRONT cycle.

Behaviour:
- Reset: every output is 0 and LB_RD_N is 1. Counters clear and the FSM enters IDLE. A reset mid-frame aborts immediately; there is no partial-line completion.
- All outputs are registered on the PCLK rising edge.
- FSM states: IDLE, VSYNC, VBACK, HACT, HBLANK, VFRONT.
- IDLE, EN=1 → VSYNC. PATTERN_SEL and SOLID_COLOR are latched on this transition; they are constant for the whole frame.
- VSYNC: CamVsync=1 for V_SYNC_CLKS cycles, then VBACK.
- VBACK: V_BACK_CLKS cycles, CamVsync=0, then HACT.
- HACT: 2*H_ACTIVE cycles with CamHsync=1.
  - Cycle k carries byte k of the line.
  - Byte 2p is pixel p bits [15:8]; byte 2p+1 is bits [7:0].
- HBLANK: H_BLANK cycles, CamHsync=0.
  - If fewer than V_ACTIVE lines have been sent, go to HACT.
  - Otherwise go to VFRONT.
- VFRONT: V_FRONT_CLKS cycles. The last cycle pulses FRAME_DONE.
  - EN=1 → VSYNC, re-latching the pattern.
  - EN=0 → IDLE.
  - Deasserting EN mid-frame never truncates the frame.
- Line-buffer reads (PATTERN_SEL=0):
  - For pixel p, LB_RD_N=0 with LB_RD_ADDR=p in the cycle two before byte 2p appears.
  - For p=0 these are the second-to-last cycle of VBACK or HBLANK.
  - Exactly one read per pixel; LB_RD_N=1 otherwise. LB_RD_ADDR holds its last value when not reading.
- Pattern paths use the same output timing as the RAM path. No reads are issued for patterns 1-3.
- Colour bars:
  - 8 bars, each H_ACTIVE/8 pixels wide, advanced by a pixel counter (no divider).
  - Order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Ramp: word = (p + line) mod 2^16.
- Solid: the latched SOLID_COLOR.
- CUR_LINE:
  - 0 from VSYNC entry.
  - Increments when each line's HACT ends; holds V_ACTIVE after the last line.
  - Reset to 0 on VSYNC entry.
- LINE_START: one cycle at VBACK entry (line 0) and at each HBLANK entry while CUR_LINE < V_ACTIVE.
- Frame length in cycles = V_SYNC_CLKS + V_BACK_CLKS + V_ACTIVE*(2*H_ACTIVE + H_BLANK) + V_FRONT_CLKS.
- Receiver compatibility: the falling edge of CamHsync ends a line, and the falling edge of CamVsync starts a frame.

Test Plan:
- Small parameters for all scenarios: H_ACTIVE=8, V_ACTIVE=2, H_BLANK=4, V_SYNC_CLKS=6, V_BACK_CLKS=4, V_FRONT_CLKS=3.
- Timing, EN=1, pattern 3 with SOLID_COLOR=A55A:
  - CamVsync high 6 cycles.
  - 2 Hsync pulses of 16 cycles each, CamData alternating A5, 5A.
  - FRAME_DONE every 53 cycles; next VSYNC starts the following cycle.
- Line buffer, pattern 0, RAM model returning 16'h1000+addr:
  - Line bytes are 10 00 10 01 … 10 07.
  - LB_RD_N pulses at addresses 0..7, each two cycles before its high byte; 8 reads per line.
- Colour bars, pattern 1: the line's byte pairs are FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
- Ramp, pattern 2: line 1 pixel 7 outputs 00 08. CUR_LINE reads 0, 1, then 2; LINE_START fires twice per frame.
- EN drop and reset:
  - EN=0 during line 0 → the frame completes, FRAME_DONE pulses, the FSM enters IDLE, all outputs 0.
  - RST_N=0 mid-HACT → CamHsync, CamData and CUR_LINE are 0 immediately, LB_RD_N=1.
- Pattern latch: change PATTERN_SEL 3→1 mid-frame → the current frame stays solid; bars start at the next frame.
